pong_ball_engine: RTL and testbench

Parametrised ball engine for the LED-grid pong game: tracks the ball on a COLS x ROWS grid, bounces it off the top and bottom walls, the far wall and the player paddle, and reports score, hit and lose events. It sits between the paddle controller and the display driver. It replaces the fixed 30x10, three-segment ball block with configurable geometry, paddle length, an explicit serve handshake, a score counter and optional speed-up.

---
 rtl/pong_ball_engine.sv | 127 ++++++++++++
 tb/tb_pong_ball_engine.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball position, bounce and scoring engine for the LED-grid pong game.
// Optional PONG_BALL_SPEEDUP_EN: a step divider that starts at START_DIV and shrinks by one on each paddle hit.
module pong_ball_engine #(
  parameter int COLS       = 30,
  parameter int ROWS       = 10,
  parameter int POS_W      = 9,
  parameter int PADDLE_LEN = 3,
  parameter int SCORE_W    = 8,
  parameter int START_DIV  = 4,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               serve,
  input  logic [RW-1:0]      paddle_row,
  output logic [CW-1:0]      ball_col,
  output logic [RW-1:0]      ball_row,
  output logic [POS_W-1:0]   ball,
  output logic               minus,
  output logic               active,
  output logic               hit,
  output logic               score,
  output logic               lose,
  output logic [SCORE_W-1:0] score_cnt
);
  typedef enum logic [1:0] {IDLE, MOVE, LOST} state_t;
  localparam logic [CW-1:0]    C0    = CW'(COLS / 2);
  localparam logic [RW-1:0]    R0    = RW'(ROWS / 2);
  localparam logic [POS_W-1:0] BALL0 = POS_W'((ROWS / 2) * COLS + COLS / 2);
  localparam logic [RW:0]      PL    = PADDLE_LEN[RW:0];
  state_t r_state;
  logic [CW-1:0] r_col, w_col_n;
  logic [RW-1:0] r_row, w_row_n;
  logic [POS_W-1:0] r_ball, w_ball_n;
  logic [SCORE_W-1:0] r_score_cnt;
  logic [RW:0] w_off;
  logic r_minus, r_up, r_dn, r_active, r_hit, r_score, r_lose;
  logic w_move, w_serve, w_pad, w_hit, w_miss, w_far, w_minus_n, w_up0, w_dn0, w_up, w_dn;
  assign w_serve = r_state != MOVE && serve;
`ifdef PONG_BALL_SPEEDUP_EN
  localparam int DW = $clog2(START_DIV + 1);
  logic [DW-1:0] r_div, r_cnt;
  assign w_move = r_state == MOVE && step && (r_cnt + DW'(1) >= r_div);
  always_ff @(posedge clk) begin
    if (reset || w_serve) begin
      r_div <= DW'(START_DIV);
      r_cnt <= '0;
    end else if (r_state == MOVE && step) begin
      r_cnt <= w_move ? '0 : r_cnt + DW'(1);
      if (w_move && w_hit && r_div > DW'(1)) r_div <= r_div - DW'(1);
    end
  end
`else
  logic w_unused_div;
  assign w_unused_div = |START_DIV;
  assign w_move = r_state == MOVE && step;
`endif
  // Move resolution: paddle, miss, far wall, then top/bottom walls on the resulting dy.
  always_comb begin
    w_off     = {1'b0, r_row} - {1'b0, paddle_row};
    w_pad     = r_minus && r_col == CW'(1);
    w_hit     = w_pad && r_row >= paddle_row && w_off < PL;
    w_miss    = w_pad && !w_hit;
    w_far     = !r_minus && r_col == CW'(COLS - 1);
    w_minus_n = w_hit ? 1'b0 : w_far ? 1'b1 : r_minus;
    w_up0     = w_hit ? w_off == '0 : r_up;
    w_dn0     = w_hit ? w_off == PL - (RW+1)'(1) : r_dn;
    w_up      = w_up0 ? r_row != '0 : (w_dn0 && r_row == RW'(ROWS - 1));
    w_dn      = w_dn0 ? r_row != RW'(ROWS - 1) : (w_up0 && r_row == '0);
    w_col_n   = w_miss ? '0 : w_minus_n ? r_col - CW'(1) : r_col + CW'(1);
    w_row_n   = w_miss ? r_row : w_up ? r_row - RW'(1) : w_dn ? r_row + RW'(1) : r_row;
    w_ball_n  = POS_W'(w_row_n) * POS_W'(COLS) + POS_W'(w_col_n);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= C0;
      r_row       <= R0;
      r_ball      <= BALL0;
      r_minus     <= 1'b1;
      r_up        <= 1'b0;
      r_dn        <= 1'b0;
      r_active    <= 1'b0;
      r_hit       <= 1'b0;
      r_score     <= 1'b0;
      r_lose      <= 1'b0;
      r_score_cnt <= '0;
    end else begin
      r_hit   <= w_move && w_hit;
      r_score <= w_move && w_far;
      r_lose  <= w_move && w_miss;
      if (w_serve) begin
        r_state  <= MOVE;
        r_active <= 1'b1;
        r_col    <= C0;
        r_row    <= R0;
        r_ball   <= BALL0;
        r_minus  <= 1'b1;
        r_up     <= 1'b0;
        r_dn     <= 1'b0;
      end else if (w_move) begin
        r_col   <= w_col_n;
        r_row   <= w_row_n;
        r_ball  <= w_ball_n;
        r_minus <= w_minus_n;
        r_up    <= w_up;
        r_dn    <= w_dn;
        if (w_miss) begin
          r_state  <= LOST;
          r_active <= 1'b0;
        end
        if (w_far && !(&r_score_cnt)) r_score_cnt <= r_score_cnt + SCORE_W'(1);
      end
    end
  end
  assign ball_col  = r_col;
  assign ball_row  = r_row;
  assign ball      = r_ball;
  assign minus     = r_minus;
  assign active    = r_active;
  assign hit       = r_hit;
  assign score     = r_score;
  assign lose      = r_lose;
  assign score_cnt = r_score_cnt;
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed scoreboard bench for pong_ball_engine with default geometry (30x10, paddle 3).
module tb_pong_ball_engine;
  logic       clk = 0, reset = 1, step = 0, serve = 0;
  logic [3:0] paddle_row = 4;
  logic [3:0] prow = 4;
  logic [4:0] ball_col;
  logic [3:0] ball_row;
  logic [8:0] ball;
  logic       minus, active, hit, score, lose;
  logic [7:0] score_cnt;
  int errs = 0, checks = 0;

  typedef struct {
    string name;
    int col, row, minus, active, hit, score, lose, cnt;
  } exp_t;
  exp_t q[$];

  pong_ball_engine dut (
    .clk(clk), .reset(reset), .step(step), .serve(serve), .paddle_row(paddle_row),
    .ball_col(ball_col), .ball_row(ball_row), .ball(ball), .minus(minus), .active(active),
    .hit(hit), .score(score), .lose(lose), .score_cnt(score_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input int act, input int req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s.%s: got %0d want %0d", n, f, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "col", int'(ball_col), e.col);
      chk(e.name, "row", int'(ball_row), e.row);
      chk(e.name, "ball", int'(ball), e.row * 30 + e.col);
      chk(e.name, "minus", int'(minus), e.minus);
      chk(e.name, "active", int'(active), e.active);
      chk(e.name, "hit", int'(hit), e.hit);
      chk(e.name, "score", int'(score), e.score);
      chk(e.name, "lose", int'(lose), e.lose);
      chk(e.name, "score_cnt", int'(score_cnt), e.cnt);
    end
  end

  task automatic tick(input logic st = 0, input logic sv = 0, input logic rs = 0);
    #1;
    step = st;
    serve = sv;
    reset = rs;
    paddle_row = prow;
    @(posedge clk);
  endtask

  task automatic ex(input string n, input int c, input int r, input int m, input int a,
                    input int h, input int s, input int l, input int k);
    exp_t e;
    e.name = n; e.col = c; e.row = r; e.minus = m; e.active = a;
    e.hit = h; e.score = s; e.lose = l; e.cnt = k;
    q.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(0, 0, 1);
    tick(0, 0, 1);
    ex("reset", 15, 5, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      ex("idle_step", 15, 5, 1, 0, 0, 0, 0, 0);
    end
    prow = 4;
    tick(0, 1);
    ex("serve", 15, 5, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      ex("approach", 15 - k, 5, 1, 1, 0, 0, 0, 0);
    end
    tick(1);
    ex("hit_mid", 2, 5, 0, 1, 1, 0, 0, 0);
    tick(0);
    ex("no_step", 2, 5, 0, 1, 0, 0, 0, 0);
    tick(0, 1);
    ex("serve_in_move", 2, 5, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 27; k++) begin
      tick(1);
      ex("to_far", 2 + k, 5, 0, 1, 0, 0, 0, 0);
    end
    tick(1);
    ex("score", 28, 5, 1, 1, 0, 1, 0, 1);
    for (int n = 2; n <= 256; n++) begin
      for (int k = 0; k < 27; k++) tick(1);
      tick(1);
      ex("rally_hit", 2, 5, 0, 1, 1, 0, 0, n - 1);
      for (int k = 0; k < 27; k++) tick(1);
      tick(1);
      ex(n > 255 ? "saturate" : "rally_score", 28, 5, 1, 1, 0, 1, 0, n > 255 ? 255 : n);
    end
    prow = 5;
    for (int k = 0; k < 27; k++) tick(1);
    tick(1);
    ex("hit_top", 2, 4, 0, 1, 1, 0, 0, 255);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      ex("rise", 2 + k, 4 - k, 0, 1, 0, 0, 0, 255);
    end
    tick(1);
    ex("top_wall", 7, 1, 0, 1, 0, 0, 0, 255);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      ex("fall", 7 + k, 1 + k, 0, 1, 0, 0, 0, 255);
    end
    tick(1);
    ex("bottom_wall", 16, 8, 0, 1, 0, 0, 0, 255);
    tick(1, 0, 1);
    ex("reset_mid", 15, 5, 1, 0, 0, 0, 0, 0);
    prow = 0;
    tick(0, 1);
    ex("serve2", 15, 5, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      ex("approach2", 15 - k, 5, 1, 1, 0, 0, 0, 0);
    end
    tick(1);
    ex("miss", 0, 5, 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      ex("lost_hold", 0, 5, 1, 0, 0, 0, 0, 0);
    end
    prow = 3;
    tick(1, 1);
    ex("serve_step", 15, 5, 1, 1, 0, 0, 0, 0);
    tick(1);
    ex("first_move", 14, 5, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) tick(1);
    tick(1);
    ex("hit_bot", 2, 6, 0, 1, 1, 0, 0, 0);
    tick(1);
    ex("descend", 3, 7, 0, 1, 0, 0, 0, 0);
    tick(0);
    tick(0);
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
